// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator family.
//   - state_t  : FSM state encodings (S_IDLE, S_SCAN)
//   - RES_*    : result codes used to decode the slice compare into EQ/LT/GT
//   - idx_width: width of the slice index counter for a given N/K
package serial_magnitude_comparator_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    localparam logic [1:0] RES_EQ = 2'd0;
    localparam logic [1:0] RES_LT = 2'd1;
    localparam logic [1:0] RES_GT = 2'd2;

    // At least one bit, so the single-slice case (K == N) still has a counter.
    function automatic int idx_width(input int n, input int k);
        int slices;
        slices = n / k;
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_slice.sv
// slice_comparator: combinational unsigned compare of two K-bit slices.
// Ports:
//   a, b : K-bit slices (unsigned)
//   eq   : a == b
//   lt   : a <  b
module slice_comparator #(
    parameter int K = 1
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic         eq,
    output logic         lt
);

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: compares two N-bit operands MSB-first, K bits
// per clock, with early exit on the first differing slice. Unsigned or
// two's-complement ordering selected per compare.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request a compare (accepted only while busy == 0)
//   signed_mode  : 1 = two's-complement, 0 = unsigned; sampled with start
//   A, B         : operands, sampled on the accepting edge
//   busy         : compare in progress
//   done         : one-cycle pulse, results valid from this cycle on
//   EQ, LT, GT   : result flags, held until the next done
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         EQ,
    output logic         LT,
    output logic         GT
);

    localparam int SLICES = N / K;
    localparam int IDX_W  = idx_width(N, K);

    generate
        if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
            $error("serial_magnitude_comparator: illegal N/K combination");
        end
    endgenerate

    state_t             r_state;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [IDX_W-1:0]   r_idx;

    logic [K-1:0]       w_slice_a;
    logic [K-1:0]       w_slice_b;
    logic               w_eq;
    logic               w_lt;
    logic [1:0]         w_res;

    // Flipping both MSBs maps two's-complement order onto unsigned order.
    logic [N-1:0]       w_msb_flip;
    assign w_msb_flip = {signed_mode, {(N-1){1'b0}}};

    assign w_slice_a = r_a[int'(r_idx)*K +: K];
    assign w_slice_b = r_b[int'(r_idx)*K +: K];

    slice_comparator #(.K(K)) u_slice (
        .a  (w_slice_a),
        .b  (w_slice_b),
        .eq (w_eq),
        .lt (w_lt)
    );

    assign w_res = w_eq ? RES_EQ : (w_lt ? RES_LT : RES_GT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            EQ      <= 1'b0;
            LT      <= 1'b0;
            GT      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Also reached in the done cycle, which allows back-to-back compares.
                    if (start) begin
                        r_a     <= A ^ w_msb_flip;
                        r_b     <= B ^ w_msb_flip;
                        r_idx   <= IDX_W'(SLICES - 1);
                        busy    <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // A differing slice decides the result; only the last
                    // equal slice can report EQ.
                    if (w_res != RES_EQ || r_idx == '0) begin
                        EQ      <= (w_res == RES_EQ);
                        LT      <= (w_res == RES_LT);
                        GT      <= (w_res == RES_GT);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
module tb_serial_magnitude_comparator;

    logic       clk;
    logic       rst;
    logic [3:0] start_v;
    logic [3:0] sm_v;
    logic [7:0] a_v [4];
    logic [7:0] b_v [4];
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] eq_v;
    logic [3:0] lt_v;
    logic [3:0] gt_v;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic eq;
        logic lt;
        logic gt;
        int   lat;
    } exp_t;

    exp_t       sb [$];
    logic [2:0] prev_res [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_magnitude_comparator #(.N(8), .K(1)) u_k1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm_v[0]),
        .A(a_v[0]), .B(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .EQ(eq_v[0]), .LT(lt_v[0]), .GT(gt_v[0]));

    serial_magnitude_comparator #(.N(8), .K(2)) u_k2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm_v[1]),
        .A(a_v[1]), .B(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .EQ(eq_v[1]), .LT(lt_v[1]), .GT(gt_v[1]));

    serial_magnitude_comparator #(.N(8), .K(4)) u_k4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm_v[2]),
        .A(a_v[2]), .B(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .EQ(eq_v[2]), .LT(lt_v[2]), .GT(gt_v[2]));

    serial_magnitude_comparator #(.N(8), .K(8)) u_k8 (
        .clk(clk), .rst(rst), .start(start_v[3]), .signed_mode(sm_v[3]),
        .A(a_v[3]), .B(b_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .EQ(eq_v[3]), .LT(lt_v[3]), .GT(gt_v[3]));

    // Reference: language comparison operators and a slice scan for latency.
    task automatic push_expected(input int ki, input logic [7:0] a, input logic [7:0] b,
                                 input logic sm);
        exp_t       e;
        int         k;
        int         slices;
        bit         found;
        logic [7:0] diff;
        k      = 1 << ki;
        slices = 8 / k;
        diff   = a ^ b;
        e.lat  = slices;
        found  = 1'b0;
        for (int s = slices - 1; s >= 0; s--) begin
            if (!found && (((diff >> (s * k)) & ((9'd1 << k) - 9'd1)) != 0)) begin
                e.lat = slices - s;
                found = 1'b1;
            end
        end
        e.eq = (a == b);
        e.lt = sm ? ($signed(a) < $signed(b)) : (a < b);
        e.gt = !e.eq && !e.lt;
        sb.push_back(e);
    endtask

    task automatic start_cmp(input int ki, input logic [7:0] a, input logic [7:0] b,
                             input logic sm);
        @(negedge clk);
        push_expected(ki, a, b, sm);
        a_v[ki]     = a;
        b_v[ki]     = b;
        sm_v[ki]    = sm;
        start_v[ki] = 1'b1;
        @(posedge clk);
        #1;
        start_v[ki] = 1'b0;
        checks++;
        if (busy_v[ki] !== 1'b1 || {eq_v[ki], lt_v[ki], gt_v[ki]} !== prev_res[ki]) begin
            failures++;
            $display("FAIL accept k_idx=%0d busy=%b res=%b expected busy=1 res=%b",
                     ki, busy_v[ki], {eq_v[ki], lt_v[ki], gt_v[ki]}, prev_res[ki]);
        end
    endtask

    task automatic wait_result(input int ki, input int cyc0);
        int   cyc;
        bit   seen;
        exp_t e;
        cyc  = cyc0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_v[ki]) seen = 1'b1;
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty k_idx=%0d", ki);
        end else begin
            e = sb.pop_front();
            if (!seen) begin
                failures++;
                $display("FAIL done_timeout k_idx=%0d waited=%0d expected latency=%0d",
                         ki, cyc, e.lat);
            end else begin
                if (cyc !== e.lat) begin
                    failures++;
                    $display("FAIL latency k_idx=%0d got=%0d expected=%0d", ki, cyc, e.lat);
                end
                checks++;
                if ({eq_v[ki], lt_v[ki], gt_v[ki]} !== {e.eq, e.lt, e.gt}) begin
                    failures++;
                    $display("FAIL result k_idx=%0d eq_lt_gt=%b expected=%b",
                             ki, {eq_v[ki], lt_v[ki], gt_v[ki]}, {e.eq, e.lt, e.gt});
                end
                checks++;
                if (busy_v[ki] !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_at_done k_idx=%0d busy=%b expected=0", ki, busy_v[ki]);
                end
                prev_res[ki] = {e.eq, e.lt, e.gt};
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start_v = '0;
        sm_v    = '0;
        for (int i = 0; i < 4; i++) begin
            a_v[i]      = '0;
            b_v[i]      = '0;
            prev_res[i] = 3'b000;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy_v[i], done_v[i], eq_v[i], lt_v[i], gt_v[i]} !== 5'b0) begin
                failures++;
                $display("FAIL reset_state k_idx=%0d busy_done_eq_lt_gt=%b expected=00000",
                         i, {busy_v[i], done_v[i], eq_v[i], lt_v[i], gt_v[i]});
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        start_cmp(0, 8'hFF, 8'hFF, 1'b0); wait_result(0, 0);
        start_cmp(0, 8'h80, 8'h7F, 1'b0); wait_result(0, 0);
        start_cmp(0, 8'h80, 8'h7F, 1'b1); wait_result(0, 0);
        start_cmp(0, 8'h12, 8'h13, 1'b0); wait_result(0, 0);
        start_cmp(0, 8'h13, 8'h12, 1'b0); wait_result(0, 0);
        start_cmp(3, 8'h01, 8'hFF, 1'b1); wait_result(3, 0);
        start_cmp(3, 8'h01, 8'hFF, 1'b0); wait_result(3, 0);
        start_cmp(2, 8'hA5, 8'hA5, 1'b1); wait_result(2, 0);
    endtask

    task automatic test_ignore_start();
        start_cmp(0, 8'h12, 8'h13, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a_v[0]     = 8'hFF;
        b_v[0]     = 8'h00;
        sm_v[0]    = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL start_while_busy busy=%b done=%b expected busy=1 done=0",
                     busy_v[0], done_v[0]);
        end
        wait_result(0, 3);
    endtask

    task automatic test_back_to_back();
        start_cmp(1, 8'h5A, 8'h5A, 1'b0);
        wait_result(1, 0);
        // Still inside the done cycle: raise start for the next compare.
        push_expected(1, 8'h9A, 8'h5A, 1'b1);
        a_v[1]     = 8'h9A;
        b_v[1]     = 8'h5A;
        sm_v[1]    = 1'b1;
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        checks++;
        if (busy_v[1] !== 1'b1 || done_v[1] !== 1'b0 || eq_v[1] !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back_accept busy=%b done=%b eq=%b expected busy=1 done=0 eq=1",
                     busy_v[1], done_v[1], eq_v[1]);
        end
        wait_result(1, 0);
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        @(negedge clk);
        a_v[0]     = 8'h12;
        b_v[0]     = 8'h13;
        sm_v[0]    = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_v[0], done_v[0], eq_v[0], lt_v[0], gt_v[0]} !== 5'b0) begin
            failures++;
            $display("FAIL reset_abort_outputs busy_done_eq_lt_gt=%b expected=00000",
                     {busy_v[0], done_v[0], eq_v[0], lt_v[0], gt_v[0]});
        end
        for (int i = 0; i < 4; i++) prev_res[i] = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done_v[0] || busy_v[0]) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_no_done saw_done_or_busy=%b expected=0", saw_done);
        end
        start_cmp(0, 8'hC3, 8'hC1, 1'b1);
        wait_result(0, 0);
    endtask

    task automatic test_sweep();
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        for (int ki = 0; ki < 4; ki++) begin
            for (int n = 0; n < 150; n++) begin
                a  = 8'($urandom);
                sm = 1'($urandom);
                case ($urandom_range(0, 3))
                    0: b = a;
                    1: b = a ^ (8'd1 << $urandom_range(0, 7));
                    default: b = 8'($urandom);
                endcase
                start_cmp(ki, a, b, sm);
                wait_result(ki, 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover entries=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
